// File: rtl/uart_rx_pkg.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// uart_rx_pkg
// Shared definitions for the UART receiver (and the future transmitter):
// FSM state encodings, default frame geometry and a small helper that
// derives the bit-centre tick index from the oversampling ratio.
// ---------------------------------------------------------------------------
package uart_rx_pkg;

    // Receiver FSM states; encodings are shared with the transmitter side.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

    localparam int DEF_OVERSAMPLE = 16;
    localparam int DEF_DATA_BITS  = 8;

    // Tick index at which the centre of a bit is reached, counting from the
    // tick that detected the falling edge of the start bit.
    function automatic int mid_tick(input int oversample);
        return (oversample / 2) - 1;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// uart_rx_if
// Bundles the receiver's line-side inputs and byte-side outputs.
//   baud_tick  oversample enable from the baud divider (1 clk wide)
//   rx         asynchronous serial line, idle high
//   rx_data    last good byte
//   rx_valid   one-clk strobe: rx_data updated
//   frame_err  one-clk strobe: stop bit sampled low
//   busy       frame in progress
// master = the receiver (sources the byte side), slave = its environment.
// ---------------------------------------------------------------------------
interface uart_rx_if #(
    parameter int DATA_BITS = 8
) ();
    logic                 baud_tick;
    logic                 rx;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 busy;

    modport master (
        input  baud_tick,
        input  rx,
        output rx_data,
        output rx_valid,
        output frame_err,
        output busy
    );

    modport slave (
        output baud_tick,
        output rx,
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  busy
    );
endinterface

// File: rtl/uart_rx_sync_2ff.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for a single asynchronous input. Both flops reset
// to RESET_VAL so the synchronised output starts at the pin's idle level.
//   clk  system clock
//   rst  asynchronous reset, active-high
//   d    asynchronous input
//   q    synchronised output (2-clk latency)
// ---------------------------------------------------------------------------
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_r <= RESET_VAL;
            q      <= RESET_VAL;
        end else begin
            meta_r <= d;
            q      <= meta_r;
        end
    end

endmodule

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// uart_rx
// Serial UART receiver (8N1 by default). The rx line is synchronised, then
// sampled at the centre of every bit using the OVERSAMPLE x baud enable.
// All state advances only on cycles with baud_tick high; the output strobes
// are single-cycle registered pulses.
//   clk   system clock, 100 MHz
//   rst   asynchronous reset, active-high
//   bus   uart_rx_if.master: baud_tick, rx in; rx_data, rx_valid,
//         frame_err, busy out
// ---------------------------------------------------------------------------
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
    input  logic      clk,
    input  logic      rst,
    uart_rx_if.master bus
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TW-1:0] MID_TICK  = TW'(mid_tick(OVERSAMPLE));
    localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    logic rx_s;

    rx_state_e            state_r,    state_n;
    logic [TW-1:0]        tick_cnt_r, tick_cnt_n;
    logic [BW-1:0]        bit_cnt_r,  bit_cnt_n;
    logic [DATA_BITS-1:0] shift_r,    shift_n;
    logic [DATA_BITS-1:0] rx_data_r,  rx_data_n;
    logic                 rx_valid_r, rx_valid_n;
    logic                 frame_err_r, frame_err_n;
    logic                 busy_r,     busy_n;
    logic                 armed_r,    armed_n;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync_rx (
        .clk (clk),
        .rst (rst),
        .d   (bus.rx),
        .q   (rx_s)
    );

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            tick_cnt_r  <= '0;
            bit_cnt_r   <= '0;
            shift_r     <= '0;
            rx_data_r   <= '0;
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
            busy_r      <= 1'b0;
            armed_r     <= 1'b0;
        end else begin
            state_r     <= state_n;
            tick_cnt_r  <= tick_cnt_n;
            bit_cnt_r   <= bit_cnt_n;
            shift_r     <= shift_n;
            rx_data_r   <= rx_data_n;
            rx_valid_r  <= rx_valid_n;
            frame_err_r <= frame_err_n;
            busy_r      <= busy_n;
            armed_r     <= armed_n;
        end
    end

    // Next-state, counter and strobe logic; everything holds without a tick
    // except the strobes, which always fall back to zero.
    always_comb begin
        state_n     = state_r;
        tick_cnt_n  = tick_cnt_r;
        bit_cnt_n   = bit_cnt_r;
        shift_n     = shift_r;
        rx_data_n   = rx_data_r;
        rx_valid_n  = 1'b0;
        frame_err_n = 1'b0;
        busy_n      = busy_r;
        armed_n     = armed_r;

        if (bus.baud_tick) begin
            case (state_r)
                ST_IDLE: begin
                    // A line that has been low since before IDLE (break, or
                    // the tail of a framing error) must go high once before
                    // a falling edge counts as a start bit.
                    if (rx_s) begin
                        armed_n = 1'b1;
                    end else begin
                        armed_n = armed_r;
                    end
                    tick_cnt_n = '0;
                    if (armed_r && !rx_s) begin
                        state_n = ST_START;
                        busy_n  = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end

                ST_START: begin
                    if (tick_cnt_r == MID_TICK) begin
                        tick_cnt_n = '0;
                        bit_cnt_n  = '0;
                        if (!rx_s) begin
                            state_n = ST_DATA;
                        end else begin
                            // Glitch shorter than half a bit: silently drop.
                            state_n = ST_IDLE;
                            busy_n  = 1'b0;
                        end
                    end else begin
                        tick_cnt_n = tick_cnt_r + TW'(1);
                    end
                end

                ST_DATA: begin
                    if (tick_cnt_r == LAST_TICK) begin
                        tick_cnt_n = '0;
                        // LSB arrives first, so shift right from the MSB.
                        shift_n = {rx_s, shift_r[DATA_BITS-1:1]};
                        if (bit_cnt_r == LAST_BIT) begin
                            state_n   = ST_STOP;
                            bit_cnt_n = '0;
                        end else begin
                            bit_cnt_n = bit_cnt_r + BW'(1);
                        end
                    end else begin
                        tick_cnt_n = tick_cnt_r + TW'(1);
                    end
                end

                ST_STOP: begin
                    if (tick_cnt_r == LAST_TICK) begin
                        tick_cnt_n = '0;
                        state_n    = ST_IDLE;
                        busy_n     = 1'b0;
                        if (rx_s) begin
                            rx_data_n  = shift_r;
                            rx_valid_n = 1'b1;
                        end else begin
                            frame_err_n = 1'b1;
                            armed_n     = 1'b0;
                        end
                    end else begin
                        tick_cnt_n = tick_cnt_r + TW'(1);
                    end
                end

                default: begin
                    state_n    = ST_IDLE;
                    tick_cnt_n = '0;
                    bit_cnt_n  = '0;
                    busy_n     = 1'b0;
                end
            endcase
        end else begin
            state_n = state_r;
        end
    end

    assign bus.rx_data   = rx_data_r;
    assign bus.rx_valid  = rx_valid_r;
    assign bus.frame_err = frame_err_r;
    assign bus.busy      = busy_r;

endmodule
